// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes and a global stall.
// Latency is 2 + ceil(clog2(WIDTH)/REG_EVERY) cycles: operand stage, prefix groups, output stage.
module ks_adder_pipe #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int L = $clog2(WIDTH);

    logic             adv_s;
    logic [WIDTH-1:0] beff_s;
    logic [WIDTH-1:0] p0_r;
    logic [WIDTH-1:0] g0_r;
    logic             c0_r;
    logic             v0_r;

    // Per-level views: index k is the input of prefix level k, index L the final result.
    logic [L:0][WIDTH-1:0]   lg_s;
    logic [L:0][WIDTH-1:0]   lx_s;
    logic [L:0]              lc_s;
    logic [L:0]              lv_s;
    logic [L-1:0][WIDTH-1:0] lp_s;

    logic [WIDTH-1:0] cv_s;
    logic [WIDTH-1:0] sn_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    assign adv_s    = out_ready | ~out_valid_r;
    assign in_ready = adv_s;
    assign beff_s   = b ^ {WIDTH{sub}};

    // Operand stage: bitwise propagate/generate and the effective carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_r <= {WIDTH{1'b0}};
            g0_r <= {WIDTH{1'b0}};
            c0_r <= 1'b0;
            v0_r <= 1'b0;
        end else if (adv_s) begin
            p0_r <= a ^ beff_s;
            g0_r <= a & beff_s;
            c0_r <= sub | cin;
            v0_r <= in_valid & adv_s;
        end
    end

    // Carry-in enters as a gray cell on bit 0, so every prefix group ending at 0 includes it.
    assign lg_s[0] = {g0_r[WIDTH-1:1], g0_r[0] | (p0_r[0] & c0_r)};
    assign lp_s[0] = p0_r;
    assign lx_s[0] = p0_r;
    assign lc_s[0] = c0_r;
    assign lv_s[0] = v0_r;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int D      = 2 ** k;
        localparam bit IS_REG = ((k + 1) % REG_EVERY == 0) || (k == L - 1);

        logic [WIDTH-1:0] gn_s;

        // Black/gray cells at distance D; lower positions pass through.
        always_comb begin
            gn_s = lg_s[k];
            for (int j = D; j < WIDTH; j++) begin
                gn_s[j] = lg_s[k][j] | (lp_s[k][j] & lg_s[k][j-D]);
            end
        end

        if (IS_REG) begin : g_reg
            logic [WIDTH-1:0] g_r;
            logic [WIDTH-1:0] x_r;
            logic             c_r;
            logic             v_r;

            // Pipeline register closing this group of prefix levels.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    g_r <= {WIDTH{1'b0}};
                    x_r <= {WIDTH{1'b0}};
                    c_r <= 1'b0;
                    v_r <= 1'b0;
                end else if (adv_s) begin
                    g_r <= gn_s;
                    x_r <= lx_s[k];
                    c_r <= lc_s[k];
                    v_r <= lv_s[k];
                end
            end

            assign lg_s[k+1] = g_r;
            assign lx_s[k+1] = x_r;
            assign lc_s[k+1] = c_r;
            assign lv_s[k+1] = v_r;
        end else begin : g_wire
            assign lg_s[k+1] = gn_s;
            assign lx_s[k+1] = lx_s[k];
            assign lc_s[k+1] = lc_s[k];
            assign lv_s[k+1] = lv_s[k];
        end

        // Group propagate is only needed by levels that still follow.
        if (k < L - 1) begin : g_pp
            logic [WIDTH-1:0] pn_s;

            // Propagate merge at distance D.
            always_comb begin
                pn_s = lp_s[k];
                for (int j = D; j < WIDTH; j++) begin
                    pn_s[j] = lp_s[k][j] & lp_s[k][j-D];
                end
            end

            if (IS_REG) begin : g_preg
                logic [WIDTH-1:0] p_r;

                // Propagate register aligned with the generate register above.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        p_r <= {WIDTH{1'b0}};
                    end else if (adv_s) begin
                        p_r <= pn_s;
                    end
                end

                assign lp_s[k+1] = p_r;
            end else begin : g_pwire
                assign lp_s[k+1] = pn_s;
            end
        end
    end

    // Carry into bit i is the group generate G[i-1:-1]; bit 0 sees c0 directly.
    assign cv_s = {lg_s[L][WIDTH-2:0], lc_s[L]};
    assign sn_s = lx_s[L] ^ cv_s;

    // Output stage: sum and flags, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= lv_s[L];
            sum_r       <= sn_s;
            cout_r      <= lg_s[L][WIDTH-1];
            ovf_r       <= lg_s[L][WIDTH-1] ^ lg_s[L][WIDTH-2];
            zero_r      <= (sn_s == {WIDTH{1'b0}});
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: three configurations (16/2, 8/1, 64/3) share clock and reset.
module tb_ks_adder_pipe;
    localparam int NI = 3;

    typedef struct {
        int          inst;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          stamp;
        bit          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   a_v;
    logic [63:0]   b_v;
    logic          cin_v;
    logic          sub_v;
    logic [NI-1:0] iv;
    logic [NI-1:0] ordy;
    logic [NI-1:0] ir_w;
    logic [NI-1:0] ov_w;
    logic [NI-1:0] co_w;
    logic [NI-1:0] of_w;
    logic [NI-1:0] z_w;
    logic [15:0]   sum0;
    logic [7:0]    sum1;
    logic [63:0]   sum2;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ks_adder_pipe #(.WIDTH(16), .REG_EVERY(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir_w[0]),
        .a(a_v[15:0]), .b(b_v[15:0]), .cin(cin_v), .sub(sub_v),
        .out_valid(ov_w[0]), .out_ready(ordy[0]), .sum(sum0),
        .cout(co_w[0]), .ovf(of_w[0]), .zero(z_w[0])
    );

    ks_adder_pipe #(.WIDTH(8), .REG_EVERY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir_w[1]),
        .a(a_v[7:0]), .b(b_v[7:0]), .cin(cin_v), .sub(sub_v),
        .out_valid(ov_w[1]), .out_ready(ordy[1]), .sum(sum1),
        .cout(co_w[1]), .ovf(of_w[1]), .zero(z_w[1])
    );

    ks_adder_pipe #(.WIDTH(64), .REG_EVERY(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir_w[2]),
        .a(a_v), .b(b_v), .cin(cin_v), .sub(sub_v),
        .out_valid(ov_w[2]), .out_ready(ordy[2]), .sum(sum2),
        .cout(co_w[2]), .ovf(of_w[2]), .zero(z_w[2])
    );

    function automatic int wid(input int i);
        return (i == 0) ? 16 : ((i == 1) ? 8 : 64);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 1) ? 5 : 4;
    endfunction

    function automatic logic [63:0] sum_of(input int i);
        case (i)
            0:       return {48'd0, sum0};
            1:       return {56'd0, sum1};
            default: return sum2;
        endcase
    endfunction

    function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o,
                                input logic z, input bit l);
        exp_t e;
        e.inst  = 0;
        e.sum   = s;
        e.cout  = c;
        e.ovf   = o;
        e.zero  = z;
        e.stamp = 0;
        e.lat   = l;
        return e;
    endfunction

    // Arithmetic reference: plain wide addition, flags from the two top carries.
    function automatic exp_t model(input int i, input logic [63:0] a, input logic [63:0] b,
                                   input logic c, input logic s);
        exp_t        e;
        logic [65:0] mask;
        logic [65:0] be;
        logic [65:0] full;
        logic [65:0] low;
        logic        c0;
        int          w;
        w    = wid(i);
        mask = (66'd1 << w) - 66'd1;
        be   = {2'b00, (s ? ~b : b)} & mask;
        c0   = s | c;
        full = ({2'b00, a} & mask) + be + {65'd0, c0};
        low  = ({2'b00, a} & (mask >> 1)) + (be & (mask >> 1)) + {65'd0, c0};
        e    = mk(full[63:0] & mask[63:0], full[w], low[w-1] ^ full[w], 1'b0, 1'b0);
        e.zero = ((full[63:0] & mask[63:0]) == 64'd0);
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic send(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s, input exp_t e, input bit chk_rdy);
        int tmo;
        tmo = 0;
        @(negedge clk);
        a_v   = a;
        b_v   = b;
        cin_v = c;
        sub_v = s;
        iv[i] = 1'b1;
        #1;
        if (chk_rdy) check("in_ready_b2b", {63'd0, ir_w[i]}, 64'd1);
        while (ir_w[i] !== 1'b1 && tmo < 40) begin
            @(negedge clk);
            #1;
            tmo++;
        end
        if (ir_w[i] === 1'b1) begin
            e.inst  = i;
            e.stamp = cyc;
            q.push_back(e);
        end else begin
            check("accept_timeout", {63'd0, ir_w[i]}, 64'd1);
        end
    endtask

    task automatic stop_in(input int i);
        @(negedge clk);
        iv[i] = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int t;
        t = 0;
        while (q.size() != 0 && t < maxc) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    // Monitor: every output transfer pops the oldest expectation and compares it.
    always @(negedge clk) begin
        exp_t e;
        #2;
        for (int i = 0; i < NI; i++) begin
            if (rst_n === 1'b1 && ov_w[i] === 1'b1 && ordy[i] === 1'b1) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", {63'd0, ov_w[i]}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("out_inst", 64'(i), 64'(e.inst));
                    check("sum", sum_of(i), e.sum);
                    check("cout", {63'd0, co_w[i]}, {63'd0, e.cout});
                    check("ovf", {63'd0, of_w[i]}, {63'd0, e.ovf});
                    check("zero", {63'd0, z_w[i]}, {63'd0, e.zero});
                    if (e.lat) check("latency", 64'(cyc - e.stamp), 64'(lat_of(i)));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic        rs;
        int          t;

        rst_n = 1'b1;
        iv    = '0;
        ordy  = '1;
        a_v   = 64'd0;
        b_v   = 64'd0;
        cin_v = 1'b0;
        sub_v = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        for (int i = 0; i < NI; i++) begin
            check("rst_out_valid", {63'd0, ov_w[i]}, 64'd0);
            check("rst_sum", sum_of(i), 64'd0);
            check("rst_flags", {61'd0, co_w[i], of_w[i], z_w[i]}, 64'd0);
            check("rst_in_ready", {63'd0, ir_w[i]}, 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single carry-through-all-bits add with latency check.
        send(0, 64'hFFFF, 64'h0001, 1'b0, 1'b0, mk(64'h0000, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
        stop_in(0);
        drain(20);

        // Subtract and overflow corner cases, back to back.
        send(0, 64'h0005, 64'h0007, 1'b1, 1'b1, mk(64'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
        send(0, 64'h8000, 64'h0001, 1'b0, 1'b1, mk(64'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0);
        send(0, 64'h7FFF, 64'h0001, 1'b0, 1'b0, mk(64'h8000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
        send(0, 64'h1234, 64'h4321, 1'b1, 1'b0, mk(64'h5556, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
        stop_in(0);
        drain(20);

        // Sustained throughput with random operands.
        for (int k = 0; k < 100; k++) begin
            ra = 64'($urandom_range(0, 65535));
            rb = 64'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(0, ra, rb, rc, rs, model(0, ra, rb, rc, rs), 1'b1);
        end
        stop_in(0);
        drain(30);

        // Backpressure: fill, stall five cycles, then drain.
        send(0, 64'h0001, 64'h0001, 1'b0, 1'b0, mk(64'h0002, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        send(0, 64'h0000, 64'h0000, 1'b0, 1'b1, mk(64'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
        send(0, 64'h8000, 64'h8000, 1'b0, 1'b0, mk(64'h0000, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        send(0, 64'hFFFF, 64'hFFFF, 1'b1, 1'b0, mk(64'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        @(negedge clk);
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_in_ready", {63'd0, ir_w[0]}, 64'd0);
            check("stall_out_valid", {63'd0, ov_w[0]}, 64'd1);
            check("stall_sum", sum_of(0), q[0].sum);
            check("stall_flags", {61'd0, co_w[0], of_w[0], z_w[0]},
                  {61'd0, q[0].cout, q[0].ovf, q[0].zero});
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        drain(20);

        // Reset with three beats in flight, per configuration.
        for (int i = 0; i < NI; i++) begin
            ordy[i] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                send(i, ra, rb, 1'b0, 1'b0, model(i, ra, rb, 1'b0, 1'b0), 1'b0);
            end
            stop_in(i);
            t = 0;
            while (ov_w[i] !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("pre_rst_out_valid", {63'd0, ov_w[i]}, 64'd1);
            #3 rst_n = 1'b0;
            #1;
            check("async_rst_out_valid", {63'd0, ov_w[i]}, 64'd0);
            q.delete();
            @(negedge clk);
            rst_n   = 1'b1;
            ordy[i] = 1'b1;
            #1;
            check("post_rst_in_ready", {63'd0, ir_w[i]}, 64'd1);
            repeat (8) @(negedge clk);
            case (i)
                0: send(0, 64'h00FF, 64'h00FF, 1'b0, 1'b1,
                        mk(64'h0000, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
                1: send(1, 64'h007F, 64'h0001, 1'b0, 1'b0,
                        mk(64'h0080, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
                default: begin
                    send(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                         mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
                    send(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                         mk(64'h0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
                end
            endcase
            stop_in(i);
            drain(20);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
